// File: rtl/cpu_control_unit.sv
// Fetch/decode/sequence controller for cpuDatapath: owns PC and IR and runs every
// instruction as FETCH -> EXEC -> WB, with HALT parking the machine in a sticky HALTED state.
module cpu_control_unit #(
    parameter int INSTR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int FS_WIDTH    = 3,
    parameter int PC_WIDTH    = 6,
    parameter int RESET_PC    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INSTR_WIDTH-1:0] instrIn,
    input  logic [INSTR_WIDTH-1:0] Dout,
    input  logic [INSTR_WIDTH-1:0] Aout,
    output logic [PC_WIDTH-1:0]    PC,
    output logic [ADDR_WIDTH-1:0]  DA,
    output logic [ADDR_WIDTH-1:0]  AA,
    output logic [ADDR_WIDTH-1:0]  BA,
    output logic [FS_WIDTH-1:0]    FS,
    output logic                   MB,
    output logic [1:0]             resultSource,
    output logic                   RW,
    output logic                   MW,
    output logic                   halted
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_WB     = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_LDI  = 4'd9;
    localparam logic [3:0] OP_LD   = 4'd10;
    localparam logic [3:0] OP_ST   = 4'd11;
    localparam logic [3:0] OP_BEQZ = 4'd12;
    localparam logic [3:0] OP_BNEZ = 4'd13;
    localparam logic [3:0] OP_JAL  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [1:0] SRC_F    = 2'd0;
    localparam logic [1:0] SRC_LINK = 2'd1;
    localparam logic [1:0] SRC_RAM  = 2'd2;
    localparam logic [1:0] SRC_IMM  = 2'd3;

    logic [1:0]             state_reg,  state_next;
    logic [PC_WIDTH-1:0]    pc_reg,     pc_next;
    logic [INSTR_WIDTH-1:0] ir_reg,     ir_next;
    logic                   taken_reg,  taken_next;
    logic [PC_WIDTH-1:0]    target_reg, target_next;
    logic                   halted_reg, halted_next;

    logic [3:0]            op;
    logic [ADDR_WIDTH-1:0] fld_d;
    logic [ADDR_WIDTH-1:0] fld_a;
    logic [ADDR_WIDTH-1:0] fld_b;
    logic [7:0]            imm8;
    logic [PC_WIDTH-1:0]   branch_offset;
    logic [PC_WIDTH-1:0]   branch_target;
    logic [PC_WIDTH-1:0]   pc_plus_one;
    logic                  dout_zero;
    logic                  unused_aout;

    assign op    = ir_reg[INSTR_WIDTH-1 -: 4];
    assign fld_d = ir_reg[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign fld_a = ir_reg[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign fld_b = ir_reg[ADDR_WIDTH-1:0];
    assign imm8  = ir_reg[7:0];

    // Offset is the 8-bit two's-complement field resized to the PC width, so targets wrap.
    assign branch_offset = PC_WIDTH'($signed(imm8));
    assign branch_target = pc_reg + branch_offset;
    assign pc_plus_one   = pc_reg + PC_WIDTH'(1);
    assign dout_zero     = (Dout == '0);

    // Only the low PC bits of Aout form a jump target.
    assign unused_aout = ^Aout[INSTR_WIDTH-1:PC_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_FETCH;
            pc_reg     <= PC_WIDTH'(RESET_PC);
            ir_reg     <= '0;
            taken_reg  <= 1'b0;
            target_reg <= '0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            taken_reg  <= taken_next;
            target_reg <= target_next;
            halted_reg <= halted_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        taken_next  = taken_reg;
        target_next = target_reg;
        halted_next = halted_reg;
        case (state_reg)
            S_FETCH: begin
                ir_next    = instrIn;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                taken_next  = 1'b0;
                target_next = '0;
                case (op)
                    OP_BEQZ: begin
                        taken_next  = dout_zero;
                        target_next = branch_target;
                    end
                    OP_BNEZ: begin
                        taken_next  = !dout_zero;
                        target_next = branch_target;
                    end
                    OP_JAL: begin
                        // Sampled before the link write in WB, so d == a still jumps to the old value.
                        taken_next  = 1'b1;
                        target_next = Aout[PC_WIDTH-1:0];
                    end
                    default: ;
                endcase
                if (op == OP_HALT) begin
                    state_next  = S_HALTED;
                    halted_next = 1'b1;
                end else begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                pc_next    = taken_reg ? target_reg : pc_plus_one;
                state_next = S_FETCH;
            end
            S_HALTED: ;
            default: state_next = S_FETCH;
        endcase
    end

    // Controls are purely a function of state and IR so reset clears them instantly.
    always_comb begin
        DA           = '0;
        AA           = '0;
        BA           = '0;
        FS           = '0;
        MB           = 1'b0;
        resultSource = SRC_F;
        RW           = 1'b0;
        MW           = 1'b0;
        if (state_reg == S_EXEC || state_reg == S_WB) begin
            DA = fld_d;
            AA = fld_a;
            BA = fld_b;
            case (op)
                OP_ADDI: begin
                    MB = 1'b1;
                    RW = (state_reg == S_WB);
                end
                OP_LDI: begin
                    resultSource = SRC_IMM;
                    RW           = (state_reg == S_WB);
                end
                OP_LD: begin
                    resultSource = SRC_RAM;
                    RW           = (state_reg == S_WB);
                end
                OP_ST:   MW = (state_reg == S_EXEC);
                OP_BEQZ: ;
                OP_BNEZ: ;
                OP_JAL: begin
                    resultSource = SRC_LINK;
                    RW           = (state_reg == S_WB);
                end
                OP_HALT: ;
                default: begin
                    FS = FS_WIDTH'(op[2:0]);
                    RW = (state_reg == S_WB);
                end
            endcase
        end
    end

    assign PC     = pc_reg;
    assign halted = halted_reg;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: a small behavioural datapath answers the controller, while an
// instruction-level model predicts PC, per-phase controls and register contents.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instrIn, Dout, Aout;
    logic [5:0]  PC;
    logic [3:0]  DA, AA, BA;
    logic [2:0]  FS;
    logic        MB;
    logic [1:0]  resultSource;
    logic        RW, MW, halted;

    always #5 clk = ~clk;

    cpu_control_unit dut (
        .clk(clk), .reset(reset), .instrIn(instrIn), .Dout(Dout), .Aout(Aout),
        .PC(PC), .DA(DA), .AA(AA), .BA(BA), .FS(FS), .MB(MB),
        .resultSource(resultSource), .RW(RW), .MW(MW), .halted(halted)
    );

    logic [15:0] prog    [64];
    logic [15:0] dp_reg  [16];
    logic [15:0] dp_ram  [64];
    logic [15:0] pre_reg [16];
    logic [15:0] m_reg   [16];
    logic [15:0] m_ram   [64];
    logic [5:0]  m_pc;
    logic        load_req = 1'b0;
    logic [15:0] dp_result;
    logic [19:0] ctrl_obs;
    int          errors = 0;
    int          checks = 0;

    assign instrIn  = prog[PC];
    assign Dout     = dp_reg[DA];
    assign Aout     = dp_reg[AA];
    assign ctrl_obs = {DA, AA, BA, FS, MB, resultSource, RW, MW};

    function automatic logic [15:0] alu(input logic [2:0] fs, input logic [15:0] a, input logic [15:0] b);
        case (fs)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    always_comb begin
        dp_result = '0;
        case (resultSource)
            2'd0: dp_result = alu(FS, Aout, MB ? {12'b0, BA} : dp_reg[BA]);
            2'd1: dp_result = {10'b0, PC + 6'd1};
            2'd2: dp_result = dp_ram[Aout[5:0]];
            default: dp_result = {{8{AA[3]}}, AA, BA};
        endcase
    end

    // Datapath stand-in: latches on the mid-cycle falling edge, as the real datapath does.
    always @(negedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) dp_reg[i] <= pre_reg[i];
            for (int j = 0; j < 64; j++) dp_ram[j] <= '0;
        end else begin
            if (RW) dp_reg[DA] <= dp_result;
            if (MW) dp_ram[Aout[5:0]] <= dp_reg[BA];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int d, input int a, input int b);
        return {4'(op), 4'(d), 4'(a), 4'(b)};
    endfunction

    function automatic logic [19:0] exp_ctrl(input logic [15:0] ir, input int ph);
        logic [3:0] op;
        logic [2:0] fs;
        logic [1:0] rs;
        logic       wb;
        op = ir[15:12];
        if (ph == 0) return '0;
        fs = (op < 4'd8) ? op[2:0] : 3'd0;
        rs = (op == 4'd9) ? 2'd3 : (op == 4'd10) ? 2'd2 : (op == 4'd14) ? 2'd1 : 2'd0;
        wb = (op <= 4'd10) || (op == 4'd14);
        return {ir[11:0], fs, (op == 4'd8), rs, (ph == 2) && wb, (ph == 1) && (op == 4'd11)};
    endfunction

    // Architectural effect of one instruction; returns 1 for HALT.
    function automatic logic isa_step(input logic [15:0] ir);
        logic [3:0]  op, d, a, b;
        logic [15:0] av, bv, dv, imm;
        logic [5:0]  npc;
        op = ir[15:12]; d = ir[11:8]; a = ir[7:4]; b = ir[3:0];
        av = m_reg[a]; bv = m_reg[b]; dv = m_reg[d];
        imm = {{8{ir[7]}}, ir[7:0]};
        npc = m_pc + 6'd1;
        case (op)
            4'd8:  m_reg[d] = av + {12'b0, b};
            4'd9:  m_reg[d] = imm;
            4'd10: m_reg[d] = m_ram[av[5:0]];
            4'd11: m_ram[av[5:0]] = bv;
            4'd12: if (dv == 0) npc = m_pc + imm[5:0];
            4'd13: if (dv != 0) npc = m_pc + imm[5:0];
            4'd14: begin m_reg[d] = {10'b0, m_pc + 6'd1}; npc = av[5:0]; end
            4'd15: return 1'b1;
            default: m_reg[d] = alu(op[2:0], av, bv);
        endcase
        m_pc = npc;
        return 1'b0;
    endfunction

    task automatic do_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = pre_reg[i];
        for (int j = 0; j < 64; j++) m_ram[j] = '0;
        m_pc = 6'd0;
        reset = 1'b0;
        load_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        load_req = 1'b0;
        check("rst_pc", 32'(PC), 32'd0);
        check("rst_ctl", 32'(ctrl_obs), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic run_prog(input string name, input int steps);
        logic [15:0] ir;
        logic        stop;
        do_reset();
        for (int s = 0; s < steps; s++) begin
            ir = prog[m_pc];
            $display("%s step %0d pc=%0d ir=%h", name, s, m_pc, ir);
            check("fetch_pc", 32'(PC), 32'(m_pc));
            check("fetch_ctl", 32'(ctrl_obs), 32'd0);
            @(posedge clk); #1;
            check("exec_ctl", 32'(ctrl_obs), 32'(exp_ctrl(ir, 1)));
            if (ir[15:12] == 4'd15) begin
                @(posedge clk); #1;
                check("halt_flag", 32'(halted), 32'd1);
                for (int c = 0; c < 20; c++) begin
                    check("halt_pc", 32'(PC), 32'(m_pc));
                    check("halt_wr", 32'({RW, MW}), 32'd0);
                    check("halt_sticky", 32'(halted), 32'd1);
                    @(posedge clk); #1;
                end
                break;
            end
            @(posedge clk); #1;
            check("wb_ctl", 32'(ctrl_obs), 32'(exp_ctrl(ir, 2)));
            stop = isa_step(ir);
            check("wb_halted", 32'(halted), 32'(stop));
            @(posedge clk); #1;
        end
        check("end_pc", 32'(PC), 32'(m_pc));
        for (int r = 0; r < 16; r++) check($sformatf("%s_r%0d", name, r), 32'(dp_reg[r]), 32'(m_reg[r]));
    endtask

    task automatic clear_all();
        for (int i = 0; i < 64; i++) prog[i] = '0;
        for (int i = 0; i < 16; i++) pre_reg[i] = '0;
    endtask

    initial begin
        // Reset asserted mid-EXEC of a store must drop MW at once and leave memory untouched.
        clear_all();
        pre_reg[1] = 16'h0020; pre_reg[4] = 16'hBEEF;
        prog[0] = enc(11, 0, 1, 4);
        do_reset();
        @(posedge clk); #1;
        check("st_exec_mw", 32'(MW), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_mw", 32'(MW), 32'd0);
        check("mid_rst_rw", 32'(RW), 32'd0);
        check("mid_rst_pc", 32'(PC), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_ram", 32'(dp_ram[32]), 32'd0);
        $display("reset-during-store done");

        clear_all();
        prog[0] = {4'd9, 4'd1, 8'h05};
        prog[1] = {4'd9, 4'd2, 8'hFD};
        prog[2] = enc(0, 3, 1, 2);
        run_prog("ldi_add", 3);
        check("ldi_add_r3", 32'(dp_reg[3]), 32'h0002);

        // Store/load round trip, then HALT at PC 4 and reset clears halted.
        clear_all();
        pre_reg[4] = 16'h1234;
        prog[0] = {4'd9, 4'd1, 8'h20};
        prog[1] = enc(11, 0, 1, 4);
        prog[2] = enc(10, 5, 1, 0);
        prog[3] = enc(0, 0, 0, 0);
        prog[4] = enc(15, 0, 0, 0);
        run_prog("st_ld_halt", 6);
        check("st_ld_r5", 32'(dp_reg[5]), 32'h1234);
        check("halt_pc4", 32'(PC), 32'd4);
        reset = 1'b0; #1;
        check("halt_cleared", 32'(halted), 32'd0);

        clear_all();
        prog[0]  = {4'd9, 4'd6, 8'h3E};
        prog[1]  = {4'd13, 4'd0, 8'h03};
        prog[2]  = enc(14, 7, 6, 0);
        prog[62] = {4'd12, 4'd0, 8'h03};
        run_prog("branch_wrap", 5);
        check("branch_pc2", 32'(PC), 32'd2);

        clear_all();
        prog[0]  = {4'd9, 4'd6, 8'h10};
        prog[1]  = enc(14, 7, 6, 0);
        prog[16] = enc(14, 6, 6, 0);
        run_prog("jal", 3);
        check("jal_pc", 32'(PC), 32'd16);
        check("jal_r7", 32'(dp_reg[7]), 32'h0002);
        check("jal_r6", 32'(dp_reg[6]), 32'h0011);

        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 64; i++) prog[i] = 16'($urandom);
            for (int i = 0; i < 16; i++) pre_reg[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            run_prog($sformatf("rand%0d", p), 40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
